aurora_tx_scheduler: RTL and testbench

Transmit-side symbol scheduler for one simplex Aurora lane. It sits between the channel initializer and the lane encoder, and decides which symbol class goes out on every clock. During channel bring-up it forwards the initializer's ordered-set request. After `init_finished` it frames user data with SCP/ECP delimiters, fills gaps with idles and preempts traffic with periodic clock-compensation (CC) sequences.

---
 rtl/aurora_tx_scheduler.sv | 173 +++++++++++++++++
 tb/tb_aurora_tx_scheduler.sv | 438 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aurora_tx_scheduler.sv
// aurora_tx_scheduler: per-lane transmit symbol scheduler.
// Init ordered sets, SCP/ECP framing, idle fill, CC preemption.
package aurora_tx_pkg;

  typedef enum logic [1:0] {
    OS_NONE = 2'd0,
    OS_SP   = 2'd1,
    OS_I    = 2'd2,
    OS_VER  = 2'd3
  } ordered_sets_e;

  localparam logic [2:0] SYM_IDLE = 3'd0;
  localparam logic [2:0] SYM_SP   = 3'd1;
  localparam logic [2:0] SYM_VER  = 3'd2;
  localparam logic [2:0] SYM_CC   = 3'd3;
  localparam logic [2:0] SYM_SCP  = 3'd4;
  localparam logic [2:0] SYM_DATA = 3'd5;
  localparam logic [2:0] SYM_ECP  = 3'd6;

endpackage

module aurora_tx_scheduler
  import aurora_tx_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int CC_PERIOD = 5000,
  parameter int CC_LEN    = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              init_finished,
  input  ordered_sets_e     ordered_sets,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  input  logic              tx_last,
  output logic              tx_ready,
  output logic [2:0]        sym_sel,
  output logic [DATA_W-1:0] sym_data,
  output logic              frame_abort
);

  localparam int CNT_W = $clog2(CC_PERIOD);
  localparam int LEN_W = $clog2(CC_LEN) + 1;

  localparam logic [CNT_W-1:0] CNT_MAX =
    CNT_W'(CC_PERIOD - 1);
  localparam logic [LEN_W-1:0] LEN_MAX =
    LEN_W'(CC_LEN - 1);

  typedef enum logic [2:0] {
    ST_INIT = 3'd0,
    ST_IDLE = 3'd1,
    ST_SCP  = 3'd2,
    ST_DATA = 3'd3,
    ST_ECP  = 3'd4,
    ST_CC   = 3'd5
  } state_e;

  state_e             state;
  state_e             cc_ret;
  logic [CNT_W-1:0]   cc_cnt;
  logic               cc_pending;
  logic [LEN_W-1:0]   cc_left;
  logic               cnt_wrap;
  logic               cc_last;
  logic               beat;

  assign cnt_wrap = (cc_cnt == CNT_MAX);
  assign cc_last  = (cc_left == LEN_MAX);
  assign tx_ready = (state == ST_DATA) && !cc_pending;
  assign beat     = tx_valid && tx_ready;

  // Scheduler FSM, CC timer and registered symbol outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_INIT;
      cc_ret      <= ST_INIT;
      cc_cnt      <= '0;
      cc_pending  <= 1'b0;
      cc_left     <= '0;
      sym_sel     <= SYM_IDLE;
      sym_data    <= '0;
      frame_abort <= 1'b0;
    end else begin
      cc_cnt      <= cnt_wrap ? '0 : cc_cnt + 1'b1;
      sym_sel     <= SYM_IDLE;
      sym_data    <= '0;
      frame_abort <= 1'b0;
      case (state)
        ST_INIT: begin
          case (ordered_sets)
            OS_SP:   sym_sel <= SYM_SP;
            OS_VER:  sym_sel <= SYM_VER;
            default: sym_sel <= SYM_IDLE;
          endcase
          if (cc_pending) begin
            cc_ret     <= ST_INIT;
            state      <= ST_CC;
            cc_pending <= 1'b0;
            cc_left    <= '0;
          end else if (init_finished) begin
            state <= ST_IDLE;
          end
        end
        ST_IDLE: begin
          if (cc_pending) begin
            cc_ret     <= ST_IDLE;
            state      <= ST_CC;
            cc_pending <= 1'b0;
            cc_left    <= '0;
          end else if (!init_finished) begin
            state <= ST_INIT;
          end else if (tx_valid) begin
            state <= ST_SCP;
          end
        end
        ST_SCP: begin
          sym_sel <= SYM_SCP;
          if (init_finished) begin
            state <= ST_DATA;
          end else begin
            state       <= ST_INIT;
            frame_abort <= 1'b1;
          end
        end
        ST_DATA: begin
          if (beat) begin
            sym_sel  <= SYM_DATA;
            sym_data <= tx_data;
          end
          if (cc_pending) begin
            cc_ret     <= ST_DATA;
            state      <= ST_CC;
            cc_pending <= 1'b0;
            cc_left    <= '0;
          end else if (!init_finished) begin
            state       <= ST_INIT;
            frame_abort <= 1'b1;
          end else if (beat && tx_last) begin
            state <= ST_ECP;
          end
        end
        ST_ECP: begin
          sym_sel <= SYM_ECP;
          if (!init_finished) begin
            state <= ST_INIT;
          end else if (tx_valid && !cc_pending) begin
            state <= ST_SCP;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_CC: begin
          sym_sel <= SYM_CC;
          if (cc_last) begin
            if (cc_ret == ST_INIT || !init_finished) begin
              state       <= ST_INIT;
              frame_abort <= (cc_ret == ST_DATA) &&
                             !init_finished;
            end else begin
              state <= cc_ret;
            end
          end else begin
            cc_left <= cc_left + 1'b1;
          end
        end
        default: state <= ST_INIT;
      endcase
      if (cnt_wrap) cc_pending <= 1'b1;
    end
  end

endmodule

// File: tb/tb_aurora_tx_scheduler.sv
// tb_aurora_tx_scheduler: scoreboard bench with a
// frame-level reference model and directed test-plan checks.
module tb_aurora_tx_scheduler;
  import aurora_tx_pkg::*;

  localparam int W = 16;
  localparam int P = 20;
  localparam int L = 6;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          init_finished = 1'b0;
  ordered_sets_e ordered_sets = OS_NONE;
  logic [W-1:0]  tx_data = '0;
  logic          tx_valid = 1'b0;
  logic          tx_last = 1'b0;
  logic          tx_ready;
  logic [2:0]    sym_sel;
  logic [W-1:0]  sym_data;
  logic          frame_abort;

  aurora_tx_scheduler #(
    .DATA_W   (W),
    .CC_PERIOD(P),
    .CC_LEN   (L)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .init_finished(init_finished),
    .ordered_sets (ordered_sets),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_last      (tx_last),
    .tx_ready     (tx_ready),
    .sym_sel      (sym_sel),
    .sym_data     (sym_data),
    .frame_abort  (frame_abort)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    int         due;
    logic       rdy;
  } rdy_t;

  typedef struct {
    int         due;
    logic [2:0] sel;
    logic [W-1:0] data;
    logic       ab;
  } exp_t;

  rdy_t rdy_q[$];
  exp_t out_q[$];

  logic [2:0]   obs_sel [int];
  logic [W-1:0] obs_data[int];
  logic         obs_ab  [int];
  logic         obs_rdy [int];

  // reference model: lane phase, CC bookkeeping
  typedef enum {M_INIT, M_IDLE, M_SCP, M_DATA,
                M_ECP, M_CC} mph_e;
  mph_e ph     = M_INIT;
  mph_e resume = M_INIT;
  bit   pend   = 1'b0;
  int   n      = 0;
  int   cc_rem = 0;
  int   last_cyc = 0;

  ordered_sets_e os_seq[10] = '{OS_SP, OS_SP, OS_SP, OS_SP,
    OS_I, OS_I, OS_I, OS_VER, OS_VER, OS_VER};
  int exp_init[10]  = '{1, 1, 1, 1, 0, 0, 0, 2, 2, 2};
  int exp_sf_sel[6] = '{4, 5, 5, 5, 6, 0};
  int exp_sf_dat[6] = '{0, 'hA001, 'hA002, 'hA003, 0, 0};
  int exp_bb_sel[8] = '{4, 5, 0, 0, 5, 6, 4, 5};

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h",
               name, cyc, act, exp);
    end
  endtask

  task automatic start_cc();
    resume = ph;
    ph     = M_CC;
    cc_rem = L;
    pend   = 1'b0;
  endtask

  task automatic model_step(input logic rst,
                            input logic init,
                            input ordered_sets_e os,
                            input logic valid,
                            input logic last,
                            input logic [W-1:0] data,
                            output logic acc,
                            output logic ab);
    rdy_t r;
    exp_t e;
    logic rdy;
    rdy = (ph == M_DATA) && !pend;
    r.due = cyc;
    r.rdy = rdy;
    rdy_q.push_back(r);
    acc = 1'b0;
    ab  = 1'b0;
    e.due  = cyc + 1;
    e.sel  = 3'd0;
    e.data = '0;
    if (!rst) begin
      ph = M_INIT; resume = M_INIT;
      pend = 1'b0; n = 0; cc_rem = 0;
    end else begin
      acc = rdy && valid;
      case (ph)
        M_INIT: begin
          if (os == OS_SP) e.sel = 3'd1;
          else if (os == OS_VER) e.sel = 3'd2;
          if (pend) start_cc();
          else if (init) ph = M_IDLE;
        end
        M_IDLE: begin
          if (pend) start_cc();
          else if (!init) ph = M_INIT;
          else if (valid) ph = M_SCP;
        end
        M_SCP: begin
          e.sel = 3'd4;
          if (init) ph = M_DATA;
          else begin ph = M_INIT; ab = 1'b1; end
        end
        M_DATA: begin
          if (acc) begin e.sel = 3'd5; e.data = data; end
          if (pend) start_cc();
          else if (!init) begin ph = M_INIT; ab = 1'b1; end
          else if (acc && last) ph = M_ECP;
        end
        M_ECP: begin
          e.sel = 3'd6;
          if (!init) ph = M_INIT;
          else if (valid && !pend) ph = M_SCP;
          else ph = M_IDLE;
        end
        default: begin
          e.sel = 3'd3;
          cc_rem--;
          if (cc_rem == 0) begin
            if (resume == M_INIT || !init) begin
              ab = (resume == M_DATA) && !init;
              ph = M_INIT;
            end else begin
              ph = resume;
            end
          end
        end
      endcase
      if (n % P == P - 1) pend = 1'b1;
      n++;
    end
    e.ab = ab;
    out_q.push_back(e);
  endtask

  task automatic drive(input logic rst,
                       input logic init,
                       input ordered_sets_e os,
                       input logic valid,
                       input logic last,
                       input logic [W-1:0] data,
                       output logic acc,
                       output logic ab);
    @(posedge clk);
    #1;
    last_cyc      = cyc;
    rst_n         = rst;
    init_finished = init;
    ordered_sets  = os;
    tx_valid      = valid;
    tx_last       = last;
    tx_data       = data;
    model_step(rst, init, os, valid, last, data, acc, ab);
  endtask

  task automatic idle(input int k, input logic init);
    logic a, b;
    repeat (k) drive(1'b1, init, OS_NONE, 1'b0, 1'b0,
                     '0, a, b);
  endtask

  task automatic do_reset();
    logic a, b;
    drive(1'b0, 1'b0, OS_NONE, 1'b0, 1'b0, '0, a, b);
    drive(1'b1, 1'b1, OS_NONE, 1'b0, 1'b0, '0, a, b);
  endtask

  task automatic push_beat(input logic [W-1:0] d,
                           input logic last,
                           input logic init,
                           output logic ab);
    logic acc;
    int budget;
    acc = 1'b0;
    ab  = 1'b0;
    budget = 40;
    while (!acc && !ab && budget > 0) begin
      drive(1'b1, init, OS_NONE, 1'b1, last, d, acc, ab);
      budget--;
    end
    check("beat_accept", 32'(acc || ab), 32'd1);
  endtask

  task automatic send_frames(input int nf,
                             input int bubble,
                             input int drop);
    for (int f = 0; f < nf; f++) begin
      logic [W-1:0] beats[8];
      logic acc, ab, v, init;
      int len, idx, budget, gap;
      len = int'($urandom_range(1, 8));
      for (int j = 0; j < 8; j++) beats[j] = W'($urandom);
      idx = 0;
      budget = 200;
      ab = 1'b0;
      while (idx < len && !ab && budget > 0) begin
        v    = ($urandom_range(99) >= bubble);
        init = !($urandom_range(99) < drop);
        drive(1'b1, init,
              ordered_sets_e'($urandom_range(3)), v,
              idx == len - 1,
              v ? beats[idx] : W'($urandom), acc, ab);
        if (acc) idx++;
        budget--;
      end
      check("frame_progress", 32'((idx == len) || ab),
            32'd1);
      gap = int'($urandom_range(0, 2));
      repeat (gap)
        drive(1'b1, 1'b1,
              ordered_sets_e'($urandom_range(3)), 1'b0,
              1'b0, '0, acc, ab);
    end
  endtask

  function automatic int count_sel(input int a,
                                   input int b,
                                   input logic [2:0] s);
    int c = 0;
    for (int i = a; i <= b; i++)
      if (obs_sel.exists(i) && obs_sel[i] === s) c++;
    return c;
  endfunction

  function automatic int count_ab(input int a, input int b);
    int c = 0;
    for (int i = a; i <= b; i++)
      if (obs_ab.exists(i) && obs_ab[i] === 1'b1) c++;
    return c;
  endfunction

  function automatic int count_rdy(input int a, input int b);
    int c = 0;
    for (int i = a; i <= b; i++)
      if (obs_rdy.exists(i) && obs_rdy[i] === 1'b1) c++;
    return c;
  endfunction

  // monitor: log outputs and compare due expectations
  always @(negedge clk) begin : mon
    rdy_t r;
    exp_t e;
    obs_sel[cyc]  = sym_sel;
    obs_data[cyc] = sym_data;
    obs_ab[cyc]   = frame_abort;
    obs_rdy[cyc]  = tx_ready;
    while (rdy_q.size() != 0 && rdy_q[0].due <= cyc) begin
      r = rdy_q.pop_front();
      check("tx_ready", 32'(tx_ready), 32'(r.rdy));
    end
    while (out_q.size() != 0 && out_q[0].due <= cyc) begin
      e = out_q.pop_front();
      check("sym_sel", 32'(sym_sel), 32'(e.sel));
      check("sym_data", 32'(sym_data), 32'(e.data));
      check("frame_abort", 32'(frame_abort), 32'(e.ab));
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog cyc=%0d got=timeout expected=done",
             cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic a, b;
    int c, s, r, i, budget, first_cc;

    // init ordered-set mapping
    drive(1'b0, 1'b0, OS_NONE, 1'b0, 1'b0, '0, a, b);
    drive(1'b0, 1'b0, OS_NONE, 1'b0, 1'b0, '0, a, b);
    c = last_cyc + 1;
    for (int k = 0; k < 10; k++)
      drive(1'b1, 1'b0, os_seq[k], 1'b0, 1'b0, '0, a, b);
    drive(1'b1, 1'b1, OS_NONE, 1'b0, 1'b0, '0, a, b);
    idle(2, 1'b1);
    for (int k = 0; k < 10; k++)
      check("init_map", 32'(obs_sel[c + 1 + k]),
            32'(exp_init[k]));
    check("init_to_idle", 32'(obs_sel[c + 11]), 32'd0);
    check("init_no_ready", 32'(count_rdy(c, c + 10)), 32'd0);

    // single 3-beat frame
    do_reset();
    c = last_cyc + 1;
    push_beat(16'hA001, 1'b0, 1'b1, b);
    push_beat(16'hA002, 1'b0, 1'b1, b);
    push_beat(16'hA003, 1'b1, 1'b1, b);
    idle(4, 1'b1);
    for (int k = 0; k < 6; k++) begin
      check("sf_sel", 32'(obs_sel[c + 2 + k]),
            32'(exp_sf_sel[k]));
      check("sf_data", 32'(obs_data[c + 2 + k]),
            32'(exp_sf_dat[k]));
    end
    check("sf_ready_cycles", 32'(count_rdy(c, c + 8)),
          32'd3);

    // bubble inside frame, then back-to-back frame
    do_reset();
    c = last_cyc + 1;
    push_beat(16'hB001, 1'b0, 1'b1, b);
    idle(2, 1'b1);
    push_beat(16'hB002, 1'b1, 1'b1, b);
    push_beat(16'hC001, 1'b0, 1'b1, b);
    push_beat(16'hC002, 1'b1, 1'b1, b);
    idle(3, 1'b1);
    for (int k = 0; k < 8; k++)
      check("b2b_sel", 32'(obs_sel[c + 2 + k]),
            32'(exp_bb_sel[k]));

    // CC preemption of a long frame
    do_reset();
    s = last_cyc + 1;
    for (int k = 0; k < 40; k++)
      push_beat(W'(32'h1000 + k), k == 39, 1'b1, b);
    idle(3, 1'b1);
    c = count_sel(s, last_cyc - 1, 3'd3);
    check("cc_data_count",
          32'(count_sel(s, last_cyc - 1, 3'd5)), 32'd40);
    check("cc_len_multiple", 32'(c % L), 32'd0);
    check("cc_seen", 32'(c > 0), 32'd1);

    // abort in DATA
    do_reset();
    s = last_cyc + 1;
    push_beat(16'hD001, 1'b0, 1'b1, b);
    drive(1'b1, 1'b0, OS_NONE, 1'b1, 1'b0, 16'hD002, a, b);
    repeat (4)
      drive(1'b1, 1'b0, OS_SP, 1'b0, 1'b0, '0, a, b);
    check("abort_once", 32'(count_ab(s, last_cyc - 1)),
          32'd1);
    check("abort_no_ecp",
          32'(count_sel(s, last_cyc - 1, 3'd6)), 32'd0);
    check("abort_init_map",
          32'(count_sel(s, last_cyc - 1, 3'd1) >= 2), 32'd1);

    // abort while CC preempts a frame
    do_reset();
    s = last_cyc + 1;
    i = 0;
    budget = 60;
    while (ph != M_CC && budget > 0) begin
      drive(1'b1, 1'b1, OS_NONE, 1'b1, 1'b0,
            W'(32'h2000 + i), a, b);
      if (a) i++;
      budget--;
    end
    check("reached_cc", 32'(ph == M_CC), 32'd1);
    budget = 20;
    b = 1'b0;
    while (!b && budget > 0) begin
      drive(1'b1, 1'b0, OS_NONE, 1'b1, 1'b0,
            W'(32'h2000 + i), a, b);
      budget--;
    end
    check("cc_abort_seen", 32'(b), 32'd1);
    idle(3, 1'b0);
    check("cc_abort_once", 32'(count_ab(s, last_cyc - 1)),
          32'd1);
    check("cc_full_len",
          32'(count_sel(s, last_cyc - 1, 3'd3)), 32'(L));

    // reset in the middle of a frame
    do_reset();
    push_beat(16'hE001, 1'b0, 1'b1, b);
    push_beat(16'hE002, 1'b0, 1'b1, b);
    drive(1'b0, 1'b1, OS_NONE, 1'b1, 1'b0, 16'hE003, a, b);
    r = last_cyc;
    idle(P + 6, 1'b1);
    check("rst_sel", 32'(obs_sel[r + 1]), 32'd0);
    check("rst_data", 32'(obs_data[r + 1]), 32'd0);
    check("rst_abort", 32'(obs_ab[r + 1]), 32'd0);
    check("rst_ready", 32'(obs_rdy[r + 1]), 32'd0);
    first_cc = -1;
    for (int k = r + 1; k < last_cyc; k++)
      if (first_cc < 0 && obs_sel[k] === 3'd3) first_cc = k;
    check("rst_first_cc", 32'(first_cc - r), 32'(P + 3));

    // randomized traffic, then with init drops
    do_reset();
    send_frames(40, 25, 0);
    send_frames(40, 20, 3);
    idle(3, 1'b1);
    @(negedge clk);
    @(negedge clk);
    #1;
    check("scoreboard_drained",
          32'(out_q.size() + rdy_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
